// File: rtl/mem_bus_arbiter.sv
// Three-port arbiter for the shared RV32I memory bus: fetch (0), load/store (1), debug loader (2).
// Optional ACCESS timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STARVE_LIMIT   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            m_req,
  input  logic [2:0]            m_we,
  input  logic [3*ADDR_W-1:0]   m_addr,
  input  logic [3*DATA_W-1:0]   m_wdata,
  output logic [2:0]            m_gnt,
  output logic [2:0]            m_rvalid,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  m_err,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic                  bus_wren,
  output logic                  bus_rden,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ready
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_TH  = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_idx, w_idx_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic [2:0]          r_gnt, w_gnt_nxt;
  logic [2:0]          r_rvalid, w_rvalid_nxt;
  logic                r_wren, w_wren_nxt;
  logic                r_rden, w_rden_nxt;
  logic [SW-1:0]       r_starve, w_starve_nxt;

  logic                w_any;
  logic                w_starved;
  logic [1:0]          w_win;
  logic                w_win_we;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic                w_dbg_win;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]       r_tcnt, w_tcnt_nxt;
  logic                r_err, w_err_nxt;
`else
  logic                w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Arbitration: lsu > fetch > dbg, except a starved dbg jumps the queue
  assign w_any     = |m_req;
  assign w_starved = m_req[2] && (r_starve >= STARVE_TH);
  assign w_dbg_win = (r_state == ST_IDLE) && (w_win == 2'd2);

  always_comb begin
    w_win = 2'd2;
    if (w_starved)     w_win = 2'd2;
    else if (m_req[1]) w_win = 2'd1;
    else if (m_req[0]) w_win = 2'd0;
  end

  always_comb begin
    w_win_we    = m_we[0];
    w_win_addr  = m_addr[0 +: ADDR_W];
    w_win_wdata = m_wdata[0 +: DATA_W];
    case (w_win)
      2'd1: begin
        w_win_we    = m_we[1];
        w_win_addr  = m_addr[ADDR_W +: ADDR_W];
        w_win_wdata = m_wdata[DATA_W +: DATA_W];
      end
      2'd2: begin
        w_win_we    = m_we[2];
        w_win_addr  = m_addr[2*ADDR_W +: ADDR_W];
        w_win_wdata = m_wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  // Debug wait counter; saturates so a long wait cannot wrap back below the limit
  always_comb begin
    w_starve_nxt = r_starve;
    if (!m_req[2] || w_dbg_win)       w_starve_nxt = '0;
    else if (r_starve != STARVE_MAX)  w_starve_nxt = r_starve + SW'(1);
  end

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rdata_nxt  = r_rdata;
    w_gnt_nxt    = 3'b000;
    w_rvalid_nxt = 3'b000;
`ifdef MEM_ARB_TIMEOUT_EN
    w_tcnt_nxt   = r_tcnt;
    w_err_nxt    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_ACCESS;
          w_idx_nxt   = w_win;
          w_we_nxt    = w_win_we;
          w_addr_nxt  = w_win_addr;
          w_wdata_nxt = w_win_wdata;
          w_gnt_nxt   = 3'b001 << w_win;
`ifdef MEM_ARB_TIMEOUT_EN
          w_tcnt_nxt  = '0;
`endif
        end
      end
      ST_ACCESS: begin
        if (bus_ready) begin
          w_state_nxt  = ST_RESP;
          w_rdata_nxt  = r_we ? '0 : bus_rdata;
          w_rvalid_nxt = 3'b001 << r_idx;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (r_tcnt == TO_LAST) begin
          w_state_nxt  = ST_RESP;
          w_rdata_nxt  = '0;
          w_rvalid_nxt = 3'b001 << r_idx;
          w_err_nxt    = 1'b1;
        end else begin
          w_tcnt_nxt   = r_tcnt + TW'(1);
        end
`endif
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_wren_nxt = (w_state_nxt == ST_ACCESS) &&  w_we_nxt;
    w_rden_nxt = (w_state_nxt == ST_ACCESS) && !w_we_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_wren   <= 1'b0;
      r_rden   <= 1'b0;
      r_starve <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_tcnt   <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata  <= w_rdata_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_wren   <= w_wren_nxt;
      r_rden   <= w_rden_nxt;
      r_starve <= w_starve_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
      r_tcnt   <= w_tcnt_nxt;
      r_err    <= w_err_nxt;
`endif
    end
  end

  assign m_gnt     = r_gnt;
  assign m_rvalid  = r_rvalid;
  assign m_rdata   = r_rdata;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_wren  = r_wren;
  assign bus_rden  = r_rden;
`ifdef MEM_ARB_TIMEOUT_EN
  assign m_err     = r_err;
`else
  assign m_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected grants/completions, a monitor checks them.
module tb_mem_bus_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      m_req, m_we, m_gnt, m_rvalid;
  logic [3*AW-1:0] m_addr;
  logic [3*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata, bus_wdata, bus_rdata;
  logic [AW-1:0]   bus_addr;
  logic            m_err, bus_wren, bus_rden, bus_ready;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wren(bus_wren), .bus_rden(bus_rden),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct { int port; int cyc; } gnt_t;
  typedef struct { int port; logic [31:0] data; logic err; int cyc; } rsp_t;
  gnt_t gnt_q[$];
  rsp_t rsp_q[$];

  function automatic logic [31:0] mem_model(logic [31:0] a);
    if (a == 32'h100) return 32'h00A00093;
    return a ^ 32'h5A5A5A5A;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_gnt"},    64'(m_gnt), 0);
    check({tag, "_rvalid"}, 64'(m_rvalid), 0);
    check({tag, "_err"},    64'(m_err), 0);
    check({tag, "_wren"},   64'(bus_wren), 0);
    check({tag, "_rden"},   64'(bus_rden), 0);
    check({tag, "_addr"},   64'(bus_addr), 0);
    check({tag, "_wdata"},  64'(bus_wdata), 0);
    check({tag, "_rdata"},  64'(m_rdata), 0);
  endtask

  // Memory responder: bus_ready after rsp_delay strobe cycles
  int rsp_delay = 0;
  int wcnt = 0;
  initial begin
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_wren || bus_rden) begin
        if (wcnt >= rsp_delay) begin
          bus_ready = 1'b1;
          bus_rdata = mem_model(bus_addr);
        end else begin
          bus_ready = 1'b0;
          bus_rdata = 32'hDEADBEEF;
        end
        wcnt++;
      end else begin
        bus_ready = 1'b0;
        bus_rdata = '0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a grant or completion
  gnt_t mon_g;
  rsp_t mon_r;
  logic [2:0] mon_oh;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_wren || bus_rden) check("strobe_excl", 64'(bus_wren & bus_rden), 0);
        if (m_gnt != 3'b000) begin
          if (gnt_q.size() == 0) begin
            check("gnt_unexpected", 64'(m_gnt), 0);
          end else begin
            mon_g  = gnt_q.pop_front();
            mon_oh = 3'b001 << mon_g.port;
            check("gnt_port", 64'(m_gnt), 64'(mon_oh));
            if (mon_g.cyc >= 0) check("gnt_cycle", 64'(cyc), 64'(mon_g.cyc));
          end
        end
        if (m_rvalid != 3'b000) begin
          if (rsp_q.size() == 0) begin
            check("rvalid_unexpected", 64'(m_rvalid), 0);
          end else begin
            mon_r  = rsp_q.pop_front();
            mon_oh = 3'b001 << mon_r.port;
            check("rvalid_port", 64'(m_rvalid), 64'(mon_oh));
            check("rdata", 64'(m_rdata), 64'(mon_r.data));
            check("err", 64'(m_err), 64'(mon_r.err));
            if (mon_r.cyc >= 0) check("rvalid_cycle", 64'(cyc), 64'(mon_r.cyc));
          end
        end else if (m_err) begin
          check("err_without_rvalid", 64'(m_rvalid), 64'(3'b111));
        end
      end
    end
  end

  task automatic wait_gnt(int p);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_gnt[p]) return;
    end
    check("gnt_wait_expired", 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_rvalid != 3'b000) begin
        @(negedge clk);
        return;
      end
    end
    check("rvalid_wait_expired", 0, 1);
  endtask

  // Issue one request from port p at a negedge while the DUT is idle; returns at the grant
  task automatic do_txn(int p, logic we, logic [31:0] a, logic [31:0] d, int dly,
                        bit push_rsp, bit chk_lat);
    gnt_t g;
    rsp_t r;
    rsp_delay = dly;
    g.port = p;
    g.cyc  = chk_lat ? cyc + 1 : -1;
    gnt_q.push_back(g);
    if (push_rsp) begin
      r.port = p;
      r.data = we ? 32'h0 : mem_model(a);
      r.err  = 1'b0;
      r.cyc  = chk_lat ? cyc + 2 + dly : -1;
      rsp_q.push_back(r);
    end
    m_we[p]              = we;
    m_addr[p*AW +: AW]   = a;
    m_wdata[p*DW +: DW]  = d;
    m_req[p]             = 1'b1;
    wait_gnt(p);
    m_req[p] = 1'b0;
  endtask

  task automatic push_pair(int gp, int rp, logic [31:0] rd, logic er, int rc);
    gnt_t g;
    rsp_t r;
    g.port = gp; g.cyc = -1;
    gnt_q.push_back(g);
    r.port = rp; r.data = rd; r.err = er; r.cyc = rc;
    rsp_q.push_back(r);
  endtask

  int wc;
  int n;
  int c0;
  initial begin
    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch read with immediate ready
    do_txn(0, 1'b0, 32'h100, 32'h0, 0, 1, 1);
    wait_done();

    // Store on lsu with ready delayed 3 cycles
    do_txn(1, 1'b1, 32'h2000, 32'hCAFEF00D, 3, 1, 1);
    wc = 0;
    for (int i = 0; i < 50 && m_rvalid == 3'b000; i++) begin
      if (bus_wren) begin
        wc++;
        check("store_addr", 64'(bus_addr), 64'h2000);
        check("store_wdata", 64'(bus_wdata), 64'hCAFEF00D);
      end
      @(negedge clk);
    end
    check("store_wren_cycles", 64'(wc), 4);
    @(negedge clk);

    // All three requesting: lsu x3, starved dbg, lsu, then fetch once lsu leaves
    rsp_delay = 0;
    push_pair(1, 1, 32'h0, 1'b0, -1);
    push_pair(1, 1, 32'h0, 1'b0, -1);
    push_pair(1, 1, 32'h0, 1'b0, -1);
    push_pair(2, 2, mem_model(32'h4000), 1'b0, -1);
    push_pair(1, 1, 32'h0, 1'b0, -1);
    push_pair(0, 0, mem_model(32'h104), 1'b0, -1);
    m_we = 3'b010;
    m_addr  = {32'h4000, 32'h3000, 32'h104};
    m_wdata = {32'h0, 32'h11111111, 32'h0};
    m_req = 3'b111;
    n = 0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (m_gnt != 3'b000) begin
        n++;
        if (m_gnt[2]) m_req[2] = 1'b0;
        if (m_gnt[0]) m_req[0] = 1'b0;
        if (n == 5)   m_req[1] = 1'b0;
      end
    end
    check("arb_grant_count", 64'(n), 6);
    m_req = 3'b000;
    wait_done();

    // Reset while a read is in ACCESS
    do_txn(2, 1'b0, 32'h500, 32'h0, 100000, 0, 0);
    @(negedge clk);
    check("pre_reset_rden", 64'(bus_rden), 1);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(2, 1'b0, 32'h504, 32'h0, 1, 1, 1);
    wait_done();

    // Memory never answers
`ifdef MEM_ARB_TIMEOUT_EN
    c0 = cyc;
    push_pair(1, 1, 32'h0, 1'b1, c0 + 17);
    rsp_delay = 100000;
    m_we[1] = 1'b0; m_addr[AW +: AW] = 32'h600; m_req[1] = 1'b1;
    wait_gnt(1);
    m_req[1] = 1'b0;
    wc = 0;
    for (int i = 0; i < 60 && m_rvalid == 3'b000; i++) begin
      if (bus_rden) wc++;
      @(negedge clk);
    end
    check("timeout_access_cycles", 64'(wc), 16);
    @(negedge clk);
    check("timeout_idle_rden", 64'(bus_rden), 0);
`else
    do_txn(1, 1'b0, 32'h600, 32'h0, 100000, 0, 0);
    repeat (100) @(negedge clk);
    check("stuck_rden", 64'(bus_rden), 1);
    check("stuck_err", 64'(m_err), 0);
    check("stuck_rvalid", 64'(m_rvalid), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    // Fresh read afterwards is served with normal latency
    do_txn(0, 1'b0, 32'h108, 32'h0, 0, 1, 1);
    wait_done();
    repeat (3) @(negedge clk);
    check("gnt_queue_drained", 64'(gnt_q.size()), 0);
    check("rsp_queue_drained", 64'(rsp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
